// File: rtl/stream_mux_rr_pkg.sv
// -----------------------------------------------------------------------------
// stream_mux_rr_pkg
//   Shared definitions for the stream multiplexer family:
//     INTERNAL_BITS       datapath word width used across the CNN datapath
//     STREAM_MODE_STATIC  mode value selecting the channel from sel_in
//     STREAM_MODE_RR      mode value selecting round-robin arbitration
//     mux_state_e         packet-lock FSM states
// -----------------------------------------------------------------------------
package stream_mux_rr_pkg;

  localparam int INTERNAL_BITS = 32;

  localparam logic STREAM_MODE_STATIC = 1'b0;
  localparam logic STREAM_MODE_RR     = 1'b1;

  // IDLE: no channel owns the output, arbitration happens here.
  // LOCKED: the granted channel owns the output until its last beat.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } mux_state_e;

endpackage : stream_mux_rr_pkg

// File: rtl/stream_mux_rr_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin first-set search. Starting at index 'start'
//   and walking upward (wrapping modulo NUM_REQ), returns the first set
//   request bit.
//
//   Ports:
//     req    in  NUM_REQ  request vector
//     start  in  IDX_W    index searched first (must be < NUM_REQ)
//     found  out 1        at least one request bit is set
//     idx    out IDX_W    index of the first set bit at or after 'start'
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Walk the offsets from farthest to nearest; the last hit written is the
  // one closest to 'start', so no early exit is needed.
  always_comb begin
    // NOTE: every output and temporary gets a default before any branch, so
    // no path leaves a value unassigned and no latch is inferred.
    found    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand     = (int'(start) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (req[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule : rr_pick

// File: rtl/stream_mux_rr.sv
// -----------------------------------------------------------------------------
// stream_mux_rr
//   N-to-1 valid/ready stream multiplexer with packet locking. A channel is
//   chosen either statically from sel_in (mode 0) or by round-robin
//   arbitration (mode 1) and then owns the output until the beat carrying
//   in_last has been accepted. The output is a single registered stage with
//   backpressure; inside a packet it sustains one beat per cycle.
//
//   Ports:
//     clk        in   1              system clock, rising edge
//     rst_n      in   1              asynchronous active-low reset
//     mode       in   1              0 = static select, 1 = round-robin
//     sel_in     in   SEL_W          static channel select (mode 0)
//     in_valid   in   NUM_CH         per-channel beat valid
//     in_data    in   NUM_CH*DATA_W  channel i at [i*DATA_W +: DATA_W]
//     in_last    in   NUM_CH         per-channel end-of-packet flag
//     in_ready   out  NUM_CH         per-channel accept, one-hot or zero
//     out_valid  out  1              output beat valid
//     out_data   out  DATA_W         output beat data
//     out_last   out  1              output end-of-packet flag
//     out_ch     out  SEL_W          source channel of the output beat
//     out_ready  in   1              downstream accept
// -----------------------------------------------------------------------------
module stream_mux_rr
  import stream_mux_rr_pkg::*;
#(
  parameter  int DATA_W = INTERNAL_BITS,
  parameter  int NUM_CH = 4,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel_in,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_last,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [SEL_W-1:0]         out_ch,
  input  logic                     out_ready
);

  mux_state_e       state, state_nxt;
  logic [SEL_W-1:0] grant, grant_nxt;
  logic [SEL_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [SEL_W-1:0] grant_inc;

  logic             rr_found;
  logic [SEL_W-1:0] rr_idx;

  logic             out_free;
  logic             in_xfer;
  logic             static_ok;

  logic [DATA_W-1:0] ch_data [NUM_CH];
  logic [DATA_W-1:0] sel_data;
  logic              sel_last;

  // ---------------------------------------------------------------------------
  // Input selection: the flat data bus is viewed as one word per channel and
  // the granted word is picked by index.
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign ch_data[i] = in_data[i*DATA_W +: DATA_W];
  end

  assign sel_data = ch_data[grant];
  assign sel_last = in_last[grant];

  // The output register can take a new beat when it is empty or when its
  // current beat leaves in this same cycle.
  assign out_free = !out_valid || out_ready;
  assign in_xfer  = (state == ST_LOCKED) && in_valid[grant] && out_free;

  // sel_in can exceed the channel count only when NUM_CH is not a power of 2;
  // such a select never grants.
  assign static_ok = (int'(sel_in) < NUM_CH) && in_valid[sel_in];

  // Channel after the granted one, wrapping at NUM_CH.
  assign grant_inc = (int'(grant) == NUM_CH - 1) ? '0 : grant + SEL_W'(1);

  rr_pick #(
    .NUM_REQ (NUM_CH),
    .IDX_W   (SEL_W)
  ) u_rr_pick (
    .req   (in_valid),
    .start (rr_ptr),
    .found (rr_found),
    .idx   (rr_idx)
  );

  // ---------------------------------------------------------------------------
  // FSM state register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state  <= ST_IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state. mode and sel_in only matter while IDLE; once LOCKED the
  // grant is held until the last beat of the packet is accepted.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    rr_ptr_nxt = rr_ptr;
    unique case (state)
      ST_IDLE: begin
        if (mode == STREAM_MODE_STATIC) begin
          if (static_ok) begin
            grant_nxt = sel_in;
            state_nxt = ST_LOCKED;
          end
        end else if (rr_found) begin
          grant_nxt = rr_idx;
          state_nxt = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        // The pointer advances in both modes so a later switch to
        // round-robin starts after the most recently served channel.
        if (in_xfer && sel_last) begin
          state_nxt  = ST_IDLE;
          rr_ptr_nxt = grant_inc;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM outputs: only the granted channel may see ready, and only while the
  // output register can take its beat.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready = '0;
    if (state == ST_LOCKED) begin
      in_ready[grant] = out_free;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register. A reload on a simultaneous in/out transfer keeps
  // out_valid high, giving one beat per cycle inside a packet.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_ch    <= '0;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_last  <= sel_last;
      out_ch    <= grant;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule : stream_mux_rr

// File: tb/tb_stream_mux_rr.sv
// -----------------------------------------------------------------------------
// tb_stream_mux_rr
//   Directed bench for stream_mux_rr (4 channels, 32-bit data). Upstream
//   channels are packet queues; a transaction-level model predicts ready,
//   output beats and arbitration each cycle, and literal beat logs pin the
//   expected packet order and timing for each scenario.
// -----------------------------------------------------------------------------
module tb_stream_mux_rr;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int SW = 2;

  logic           clk;
  logic           rst_n;
  logic           mode;
  logic [SW-1:0]  sel_in;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic [SW-1:0]  out_ch;
  logic           out_ready;

  stream_mux_rr #(
    .DATA_W (W),
    .NUM_CH (N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel_in    (sel_in),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  typedef struct {
    int           ch;
    logic [W-1:0] d;
    logic         l;
    int           cyc;
  } obs_t;

  beat_t        src_q [N][$];
  obs_t         log_q [$];
  logic [W-1:0] stall_d [$];
  logic [N-1:0] hs;

  int cyc;
  int n_checks;
  int n_errors;

  // Model: which channel owns the output, the round-robin start point and
  // the contents of the single output slot.
  bit           m_locked;
  int           m_g;
  int           m_ptr;
  bit           m_ov;
  logic [W-1:0] m_od;
  logic         m_ol;
  int           m_oc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int ch, input logic [W-1:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    src_q[ch].push_back(b);
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        in_valid[i]         = 1'b1;
        in_data[i*W +: W]   = src_q[i][0].d;
        in_last[i]          = src_q[i][0].l;
      end else begin
        in_valid[i]         = 1'b0;
        in_data[i*W +: W]   = '0;
        in_last[i]          = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_g      = 0;
    m_ptr    = 0;
    m_ov     = 1'b0;
    m_od     = '0;
    m_ol     = 1'b0;
    m_oc     = 0;
  endtask

  // Channel the arbiter would choose from IDLE, or -1 for none.
  function automatic int model_pick();
    if (mode == 1'b0) begin
      if (int'(sel_in) < N && in_valid[sel_in]) return int'(sel_in);
      return -1;
    end
    for (int k = 0; k < N; k++) begin
      if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  // Compare the DUT against the model for the current cycle, then advance
  // the model to the next cycle.
  task automatic model_step();
    logic [N-1:0] exp_rdy;
    bit           in_x;
    int           pick;
    exp_rdy = '0;
    if (m_locked && (!m_ov || out_ready)) exp_rdy[m_g] = 1'b1;

    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, m_ov);
    if (m_ov) begin
      check("out_data", out_data, m_od);
      check("out_last", out_last, m_ol);
      check("out_ch", out_ch, m_oc);
    end

    hs = in_valid & in_ready;
    if (out_valid && out_ready) log_q.push_back('{int'(out_ch), out_data, out_last, cyc});
    if (out_valid && !out_ready) stall_d.push_back(out_data);

    in_x = m_locked && in_valid[m_g] && exp_rdy[m_g];
    if (in_x) begin
      m_ov = 1'b1;
      m_od = in_data[m_g*W +: W];
      m_ol = in_last[m_g];
      m_oc = m_g;
    end else if (m_ov && out_ready) begin
      m_ov = 1'b0;
    end

    if (!m_locked) begin
      pick = model_pick();
      if (pick >= 0) begin
        m_locked = 1'b1;
        m_g      = pick;
      end
    end else if (in_x && in_last[m_g]) begin
      m_locked = 1'b0;
      m_ptr    = (m_g + 1) % N;
    end
  endtask

  // One clock cycle: entered and left just after a rising edge.
  task automatic cycle(input logic rdy);
    out_ready = rdy;
    drive_inputs();
    #1;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) void'(src_q[i].pop_front());
    end
  endtask

  task automatic run(input int n, input logic [31:0] rdy_mask);
    for (int k = 0; k < n; k++) cycle(rdy_mask[k]);
  endtask

  task automatic check_log(input string name, input int idx, input int ch,
                           input logic [W-1:0] d, input logic l);
    if (idx < log_q.size()) begin
      check({name, "_ch"}, log_q[idx].ch, ch);
      check({name, "_data"}, log_q[idx].d, d);
      check({name, "_last"}, log_q[idx].l, l);
    end else begin
      check({name, "_missing"}, log_q.size(), idx + 1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_out_ch"}, out_ch, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    mode      = 1'b1;
    sel_in    = '0;
    out_ready = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    in_last   = '0;
    model_reset();

    // ---- Reset with every channel valid, then round-robin ----
    push(0, 32'h10, 1'b1);
    push(0, 32'h14, 1'b1);
    push(1, 32'h11, 1'b1);
    push(2, 32'h12, 1'b1);
    push(3, 32'h13, 1'b1);
    drive_inputs();
    #2;
    check_reset_outputs("rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_outputs("rst_edges");
    rst_n = 1'b1;

    log_q.delete();
    run(12, '1);
    check("rr_beats", log_q.size(), 5);
    check_log("rr0", 0, 0, 32'h10, 1'b1);
    check_log("rr1", 1, 1, 32'h11, 1'b1);
    check_log("rr2", 2, 2, 32'h12, 1'b1);
    check_log("rr3", 3, 3, 32'h13, 1'b1);
    check_log("rr4", 4, 0, 32'h14, 1'b1);
    if (log_q.size() == 5) begin
      for (int i = 1; i < 5; i++) check("rr_spacing", log_q[i].cyc - log_q[i-1].cyc, 2);
    end
    check("model_ptr_rr", m_ptr, 1);

    // ---- Static select of ch2 while ch0/ch1 wait ----
    mode   = 1'b0;
    sel_in = 2'd2;
    push(2, 32'hA1, 1'b0);
    push(2, 32'hA2, 1'b0);
    push(2, 32'hA3, 1'b1);
    push(0, 32'hB0, 1'b1);
    push(1, 32'hC0, 1'b1);
    log_q.delete();
    run(6, '1);
    check("static_beats", log_q.size(), 3);
    check_log("st0", 0, 2, 32'hA1, 1'b0);
    check_log("st1", 1, 2, 32'hA2, 1'b0);
    check_log("st2", 2, 2, 32'hA3, 1'b1);
    if (log_q.size() == 3) begin
      check("st_b2b_0", log_q[1].cyc - log_q[0].cyc, 1);
      check("st_b2b_1", log_q[2].cyc - log_q[1].cyc, 1);
    end
    check("st_ch0_waiting", src_q[0].size(), 1);
    check("st_ch1_waiting", src_q[1].size(), 1);
    check("model_ptr_static", m_ptr, 3);

    // Switching to round-robin continues after ch2 (pointer 3 -> ch0, ch1).
    mode = 1'b1;
    log_q.delete();
    run(6, '1);
    check("drain_beats", log_q.size(), 2);
    check_log("dr0", 0, 0, 32'hB0, 1'b1);
    check_log("dr1", 1, 1, 32'hC0, 1'b1);
    check("model_ptr_drain", m_ptr, 2);

    // ---- Backpressure mid-packet on ch1 (out_ready low on cycles 3..5) ----
    push(1, 32'hD1, 1'b0);
    push(1, 32'hD2, 1'b0);
    push(1, 32'hD3, 1'b0);
    push(1, 32'hD4, 1'b1);
    log_q.delete();
    stall_d.delete();
    run(10, 32'hFFFF_FFC7);
    check("bp_beats", log_q.size(), 4);
    check_log("bp0", 0, 1, 32'hD1, 1'b0);
    check_log("bp1", 1, 1, 32'hD2, 1'b0);
    check_log("bp2", 2, 1, 32'hD3, 1'b0);
    check_log("bp3", 3, 1, 32'hD4, 1'b1);
    check("bp_stall_cycles", stall_d.size(), 3);
    foreach (stall_d[i]) check("bp_hold_data", stall_d[i], 32'hD2);
    if (log_q.size() >= 3) check("bp_resume_b2b", log_q[2].cyc - log_q[1].cyc, 1);

    // ---- Packet lock: mode/sel_in change during a ch1 packet ----
    push(1, 32'hE1, 1'b0);
    push(1, 32'hE2, 1'b0);
    push(1, 32'hE3, 1'b1);
    log_q.delete();
    run(2, '1);
    mode   = 1'b0;
    sel_in = 2'd0;
    push(0, 32'hF0, 1'b1);
    run(8, '1);
    check("lock_beats", log_q.size(), 4);
    check_log("lk0", 0, 1, 32'hE1, 1'b0);
    check_log("lk1", 1, 1, 32'hE2, 1'b0);
    check_log("lk2", 2, 1, 32'hE3, 1'b1);
    check_log("lk3", 3, 0, 32'hF0, 1'b1);
    check("model_ptr_lock", m_ptr, 1);

    // ---- Reset after 2 of 4 beats on ch2 ----
    mode = 1'b1;
    push(2, 32'h51, 1'b0);
    push(2, 32'h52, 1'b0);
    push(2, 32'h53, 1'b0);
    push(2, 32'h54, 1'b1);
    log_q.delete();
    run(3, '1);
    check("mid_pkt_valid", out_valid, 1);
    check("mid_pkt_data", out_data, 32'h52);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("mid_rst");
    @(posedge clk);
    #1;
    check_reset_outputs("mid_rst_edge");
    for (int i = 0; i < N; i++) src_q[i].delete();
    rst_n = 1'b1;

    // Pointer back at 0: ch0 must win over ch3.
    push(3, 32'h30, 1'b1);
    push(0, 32'h40, 1'b1);
    log_q.delete();
    run(6, '1);
    check("post_rst_beats", log_q.size(), 2);
    check_log("pr0", 0, 0, 32'h40, 1'b1);
    check_log("pr1", 1, 3, 32'h30, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_stream_mux_rr
